// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin, burst-bounded arbiter sharing one 1-cycle-latency font ROM
// Ports: clk, reset_n (sync, active-low); req/addr from NUM_REQ renderers; gnt (combinational)
// and rsp_valid (one cycle later) per renderer; rsp_data passes rom_data through; rom_addr drives the ROM.
// Optional macro FONT_ARB_PRIO_EN: requester 0 preempts any burst and freezes the arbitration state.
module font_rom_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [PW-1:0] ptr, owner, start, win, idx, sel;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] issue_q;
  logic [ADDR_WIDTH-1:0] a [NUM_REQ];
  logic found, keep, prio;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign a[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end
`ifdef FONT_ARB_PRIO_EN
  assign prio = req[0];
`else
  assign prio = 1'b0;
`endif
  assign keep  = state == OWN && req[owner] && cnt < CW'(MAX_BURST);
  // a finished burst restarts the search just past the owner, so the owner is scanned last
  assign start = state == OWN ? (owner == PW'(NUM_REQ - 1) ? '0 : owner + PW'(1)) : ptr;
  always_comb begin
    found = 1'b0;
    win   = start;
    idx   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(start) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign sel       = prio ? '0 : keep ? owner : win;
  assign gnt       = (reset_n && (prio || keep || found)) ? NUM_REQ'(1) << sel : '0;
  assign rom_addr  = |gnt ? a[sel] : '0;
  assign rsp_valid = reset_n ? issue_q : '0;
  assign rsp_data  = rom_data;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      issue_q <= '0;
    end else begin
      issue_q <= gnt;
      if (!prio) begin
        if (keep) begin
          cnt <= cnt + CW'(1);
        end else begin
          if (state == OWN) ptr <= start;
          state <= found ? OWN : IDLE;
          if (found) begin
            owner <= win;
            cnt   <= CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] req = 2'b11;
  logic [21:0] addr = '0;
  logic [1:0] gnt4, gnt16, rv4, rv16;
  logic [7:0] rd4, rd16, rom4, rom16;
  logic [10:0] ra4, ra16;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rom4  <= ra4[7:0] ^ 8'h5A;
    rom16 <= ra16[7:0] ^ 8'h5A;
  end
  font_rom_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(11), .DATA_WIDTH(8), .MAX_BURST(4)) d4 (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt4),
    .rsp_valid(rv4), .rsp_data(rd4), .rom_addr(ra4), .rom_data(rom4));
  font_rom_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(11), .DATA_WIDTH(8), .MAX_BURST(16)) d16 (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt16),
    .rsp_valid(rv16), .rsp_data(rd16), .rom_addr(ra16), .rom_data(rom16));

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    addr = {11'h2AB, 11'h100};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++; if (gnt4 !== 2'b00) begin fails++; $display("FAIL reset_gnt4 got %b want 00", gnt4); end
      checks++; if (gnt16 !== 2'b00) begin fails++; $display("FAIL reset_gnt16 got %b want 00", gnt16); end
      checks++; if (ra16 !== 11'h000) begin fails++; $display("FAIL reset_rom_addr got %h want 000", ra16); end
      checks++; if (rv16 !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", rv16); end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    reset_n = 1'b1;
    req = 2'b01;
    addr = {11'h000, 11'h041};
    #1;
    checks++; if (gnt16 !== 2'b01) begin fails++; $display("FAIL single_gnt got %b want 01", gnt16); end
    checks++; if (ra16 !== 11'h041) begin fails++; $display("FAIL single_rom_addr got %h want 041", ra16); end
    checks++; if (rv16 !== 2'b00) begin fails++; $display("FAIL single_rv0 got %b want 00", rv16); end
    @(negedge clk);
    req = 2'b00;
    #1;
    checks++; if (gnt16 !== 2'b00) begin fails++; $display("FAIL single_gnt1 got %b want 00", gnt16); end
    checks++; if (rv16 !== 2'b01) begin fails++; $display("FAIL single_rv1 got %b want 01", rv16); end
    checks++; if (rd16 !== 8'h1B) begin fails++; $display("FAIL single_data got %h want 1b", rd16); end
    @(negedge clk);
    #1;
    checks++; if (rv16 !== 2'b00 || gnt16 !== 2'b00) begin fails++; $display("FAIL single_idle got rv=%b gnt=%b want 00", rv16, gnt16); end
  endtask

  task automatic test_burst();
    logic [1:0] exp, prev;
    do_reset();
    addr = {11'h2AB, 11'h100};
    prev = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req = 2'b11;
      #1;
      exp = ((k / 4) % 2) == 1 ? 2'b10 : 2'b01;
      checks++; if (gnt4 !== exp) begin fails++; $display("FAIL burst_gnt[%0d] got %b want %b", k, gnt4, exp); end
      checks++; if (ra4 !== (exp == 2'b01 ? 11'h100 : 11'h2AB)) begin fails++; $display("FAIL burst_addr[%0d] got %h", k, ra4); end
      checks++; if (rv4 !== prev) begin fails++; $display("FAIL burst_rv[%0d] got %b want %b", k, rv4, prev); end
      if (k > 0) begin
        checks++; if (rd4 !== (prev == 2'b01 ? 8'h5A : 8'hF1)) begin fails++; $display("FAIL burst_data[%0d] got %h", k, rd4); end
      end
      prev = exp;
    end
  endtask

  task automatic test_early_drop();
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = k < 2 ? 2'b11 : 2'b10;
      #1;
      exp = k < 2 ? 2'b01 : 2'b10;
      checks++; if (gnt16 !== exp) begin fails++; $display("FAIL drop_gnt[%0d] got %b want %b", k, gnt16, exp); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req = 2'b01;
      #1;
      checks++; if (gnt16 !== 2'b01) begin fails++; $display("FAIL wrap_gnt[%0d] got %b want 01", k, gnt16); end
      checks++; if (int'(d16.cnt) != (k == 0 ? 0 : ((k - 1) % 16) + 1)) begin fails++; $display("FAIL wrap_cnt[%0d] got %0d", k, d16.cnt); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req = 2'b10;
    #1;
    checks++; if (gnt16 !== 2'b10) begin fails++; $display("FAIL mid_gnt got %b want 10", gnt16); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset_n = 1'b0;
      req = 2'b11;
      #1;
      checks++; if (rv16 !== 2'b00) begin fails++; $display("FAIL mid_rv[%0d] got %b want 00", k, rv16); end
      checks++; if (gnt16 !== 2'b00) begin fails++; $display("FAIL mid_gnt_rst[%0d] got %b want 00", k, gnt16); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (gnt16 !== 2'b01) begin fails++; $display("FAIL mid_first got %b want 01", gnt16); end
    checks++; if (rv16 !== 2'b00) begin fails++; $display("FAIL mid_rv_rel got %b want 00", rv16); end
    @(negedge clk);
    req = 2'b00;
    #1;
    checks++; if (rv16 !== 2'b01) begin fails++; $display("FAIL mid_rv_after got %b want 01", rv16); end
  endtask

  task automatic test_prio();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req = 2'b10;
      #1;
      checks++; if (gnt16 !== 2'b10) begin fails++; $display("FAIL prio_own[%0d] got %b want 10", k, gnt16); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 2'b11;
      #1;
      checks++; if (gnt16 !== 2'b01) begin fails++; $display("FAIL prio_pre[%0d] got %b want 01", k, gnt16); end
      checks++; if (int'(d16.cnt) != 2) begin fails++; $display("FAIL prio_cnt[%0d] got %0d want 2", k, d16.cnt); end
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req = 2'b10;
      #1;
      checks++; if (gnt16 !== 2'b10) begin fails++; $display("FAIL prio_resume[%0d] got %b want 10", k, gnt16); end
    end
    @(negedge clk);
    #1;
    checks++; if (int'(d16.cnt) != 16) begin fails++; $display("FAIL prio_end_cnt got %0d want 16", d16.cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef FONT_ARB_PRIO_EN
    test_prio();
`else
    test_burst();
    test_early_drop();
`endif
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
